// File: rtl/sparse_chunk_writer_pkg.sv
// Shared types and sizing for the sparse chunk writer: beat/chunk counter widths and FSM state codes.
// No logic of its own. NZ_STATS_EN adds the nz_cnt_t users in the top and interface.
package sparse_chunk_writer_pkg;
   localparam int BUS_SIZE       = 32;
   localparam int WR_DAT_CYC_NUM = 4;
   localparam int SRAM_NUM       = 16;

   localparam int DAT_W = $clog2(WR_DAT_CYC_NUM);
   localparam int CHK_W = $clog2(SRAM_NUM);
   localparam int PC_W  = $clog2(BUS_SIZE + 1);
   localparam int NZ_W  = $clog2(BUS_SIZE * WR_DAT_CYC_NUM + 1);

   typedef logic [BUS_SIZE*8-1:0] beat_t;
   typedef logic [BUS_SIZE-1:0]   smap_t;
   typedef logic [DAT_W-1:0]      dat_cnt_t;
   typedef logic [CHK_W-1:0]      chunk_cnt_t;
   typedef logic [CHK_W:0]        chunk_num_t;
   typedef logic [PC_W-1:0]       popcnt_t;
   typedef logic [NZ_W-1:0]       nz_cnt_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam dat_cnt_t DAT_LAST = dat_cnt_t'(WR_DAT_CYC_NUM - 1);
endpackage

// File: rtl/sparse_chunk_writer_if.sv
// Control, dense-beat input and SRAM write-port bundle of the sparse chunk writer.
// NZ_STATS_EN adds the per-chunk nonzero byte count outputs.
interface sparse_chunk_writer_if;
   import sparse_chunk_writer_pkg::*;

   logic       start_i;
   chunk_num_t chunk_num_i;
   logic       busy_o;
   logic       done_o;
   logic       in_valid_i;
   logic       in_ready_o;
   beat_t      in_data_i;
   smap_t      wr_sparsemap_o;
   beat_t      wr_nonzero_data_o;
   logic       wr_valid_o;
   dat_cnt_t   wr_dat_count_o;
   chunk_cnt_t wr_chunk_count_o;
`ifdef NZ_STATS_EN
   nz_cnt_t    nz_count_o;
   logic       nz_count_valid_o;
`endif

   modport slave (
      input  start_i, chunk_num_i, in_valid_i, in_data_i,
      output busy_o, done_o, in_ready_o, wr_sparsemap_o, wr_nonzero_data_o,
             wr_valid_o, wr_dat_count_o, wr_chunk_count_o
`ifdef NZ_STATS_EN
      , output nz_count_o, nz_count_valid_o
`endif
   );

   modport master (
      output start_i, chunk_num_i, in_valid_i, in_data_i,
      input  busy_o, done_o, in_ready_o, wr_sparsemap_o, wr_nonzero_data_o,
             wr_valid_o, wr_dat_count_o, wr_chunk_count_o
`ifdef NZ_STATS_EN
      , input nz_count_o, nz_count_valid_o
`endif
   );
endinterface

// File: rtl/sparse_chunk_writer_beat_compactor.sv
// Combinational zero-compaction of one dense beat into {sparsemap, left-packed nonzero bytes}.
// Zero latency, no handshake; also reports the nonzero byte count.
module sparse_beat_compactor
   import sparse_chunk_writer_pkg::*;
(
   input  beat_t   data_i,
   output smap_t   sparsemap_o,
   output beat_t   packed_o,
   output popcnt_t popcount_o
);
   smap_t                         flag;
   logic [BUS_SIZE-1:0][PC_W-1:0] prefix;

   // prefix[i] = number of nonzero lanes below i = destination lane of byte i
   always_comb begin
      popcnt_t acc;
      acc    = '0;
      flag   = '0;
      prefix = '0;
      for (int i = 0; i < BUS_SIZE; i++) begin
         flag[i]   = |data_i[i*8 +: 8];
         prefix[i] = acc;
         acc       = acc + popcnt_t'(flag[i]);
      end
      popcount_o = acc;
   end

   always_comb begin
      packed_o = '0;
      for (int j = 0; j < BUS_SIZE; j++) begin
         for (int i = j; i < BUS_SIZE; i++) begin
            if (flag[i] && (prefix[i] == popcnt_t'(j))) begin
               packed_o[j*8 +: 8] = data_i[i*8 +: 8];
            end
         end
      end
   end

   assign sparsemap_o = flag;
endmodule

// File: rtl/sparse_chunk_writer.sv
// Loads a programmed number of chunks into an SRAM, one zero-compacted write per accepted beat, latency 1.
// Always ready while loading; no SRAM backpressure. NZ_STATS_EN adds per-chunk nonzero byte counts.
module sparse_chunk_writer
   import sparse_chunk_writer_pkg::*;
(
   input logic                 clk_i,
   input logic                 rst_i,
   sparse_chunk_writer_if.slave bus
);
   logic [1:0] state_q, state_d;
   dat_cnt_t   dat_q, dat_d;
   chunk_cnt_t chunk_q, chunk_d;
   chunk_num_t chunk_num_q, chunk_num_d;

   smap_t      map_q;
   beat_t      nzd_q;
   logic       wr_valid_q;
   dat_cnt_t   wr_dat_q;
   chunk_cnt_t wr_chunk_q;

   smap_t   cmp_map;
   beat_t   cmp_data;
   popcnt_t cmp_pop;

   logic accept;
   logic start_ok;
   logic last_beat;

   sparse_beat_compactor u_compactor (
      .data_i      (bus.in_data_i),
      .sparsemap_o (cmp_map),
      .packed_o    (cmp_data),
      .popcount_o  (cmp_pop)
   );

   assign accept    = bus.in_valid_i && (state_q == ST_LOAD);
   assign start_ok  = (state_q == ST_IDLE) && bus.start_i && (bus.chunk_num_i != '0);
   assign last_beat = (dat_q == DAT_LAST) && ({1'b0, chunk_q} == (chunk_num_q - chunk_num_t'(1)));

   always_comb begin
      state_d     = state_q;
      dat_d       = dat_q;
      chunk_d     = chunk_q;
      chunk_num_d = chunk_num_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d     = ST_LOAD;
               dat_d       = '0;
               chunk_d     = '0;
               chunk_num_d = bus.chunk_num_i;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               if (dat_q == DAT_LAST) begin
                  dat_d = '0;
                  // final chunk keeps its index so a full SRAM load never wraps the slot counter
                  if (last_beat) state_d = ST_DONE;
                  else           chunk_d = chunk_q + chunk_cnt_t'(1);
               end else begin
                  dat_d = dat_q + dat_cnt_t'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         dat_q       <= '0;
         chunk_q     <= '0;
         chunk_num_q <= '0;
         map_q       <= '0;
         nzd_q       <= '0;
         wr_valid_q  <= 1'b0;
         wr_dat_q    <= '0;
         wr_chunk_q  <= '0;
      end else begin
         state_q     <= state_d;
         dat_q       <= dat_d;
         chunk_q     <= chunk_d;
         chunk_num_q <= chunk_num_d;
         wr_valid_q  <= accept;
         if (accept) begin
            map_q      <= cmp_map;
            nzd_q      <= cmp_data;
            wr_dat_q   <= dat_q;
            wr_chunk_q <= chunk_q;
         end
      end
   end

   assign bus.busy_o            = (state_q != ST_IDLE);
   assign bus.done_o            = (state_q == ST_DONE);
   assign bus.in_ready_o        = (state_q == ST_LOAD);
   assign bus.wr_sparsemap_o    = map_q;
   assign bus.wr_nonzero_data_o = nzd_q;
   assign bus.wr_valid_o        = wr_valid_q;
   assign bus.wr_dat_count_o    = wr_dat_q;
   assign bus.wr_chunk_count_o  = wr_chunk_q;

`ifdef NZ_STATS_EN
   nz_cnt_t nz_acc_q;
   nz_cnt_t nz_count_q;
   logic    nz_valid_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         nz_acc_q   <= '0;
         nz_count_q <= '0;
         nz_valid_q <= 1'b0;
      end else begin
         nz_valid_q <= 1'b0;
         if (start_ok) begin
            nz_acc_q <= '0;
         end else if (accept) begin
            if (dat_q == DAT_LAST) begin
               nz_count_q <= nz_acc_q + nz_cnt_t'(cmp_pop);
               nz_valid_q <= 1'b1;
               nz_acc_q   <= '0;
            end else begin
               nz_acc_q <= nz_acc_q + nz_cnt_t'(cmp_pop);
            end
         end
      end
   end

   assign bus.nz_count_o       = nz_count_q;
   assign bus.nz_count_valid_o = nz_valid_q;
`else
   logic unused_pop;
   assign unused_pop = ^cmp_pop;
`endif
endmodule

// File: tb/tb_sparse_chunk_writer.sv
// Directed bench for sparse_chunk_writer: compaction vector table over a 2-chunk load, plus
// reset, ignored-start, gapped full-SRAM load and (with NZ_STATS_EN) nonzero statistics sequences.
module tb_sparse_chunk_writer;
   import sparse_chunk_writer_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sparse_chunk_writer_if bus ();

   sparse_chunk_writer dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      beat_t data;
      smap_t map;
      beat_t packd;
   } vec_t;

   vec_t vec [8];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_load(input int n);
      @(negedge clk);
      bus.start_i     = 1'b1;
      bus.chunk_num_i = chunk_num_t'(n);
      @(negedge clk);
      bus.start_i     = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " wr_valid"}, 256'(bus.wr_valid_o), 256'(0));
      check({tag, " busy"},     256'(bus.busy_o), 256'(0));
      check({tag, " done"},     256'(bus.done_o), 256'(0));
      check({tag, " in_ready"}, 256'(bus.in_ready_o), 256'(0));
      check({tag, " map"},      256'(bus.wr_sparsemap_o), 256'(0));
      check({tag, " data"},     256'(bus.wr_nonzero_data_o), 256'(0));
      check({tag, " dat_cnt"},  256'(bus.wr_dat_count_o), 256'(0));
      check({tag, " chk_cnt"},  256'(bus.wr_chunk_count_o), 256'(0));
`ifdef NZ_STATS_EN
      check({tag, " nz_cnt"},   256'(bus.nz_count_o), 256'(0));
      check({tag, " nz_vld"},   256'(bus.nz_count_valid_o), 256'(0));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      vec[0] = '{data: 256'h07000500, map: 32'h0000000A, packd: 256'h0705};
      vec[1] = '{data: '0, map: '0, packd: '0};
      for (int i = 0; i < BUS_SIZE; i++) vec[2].data[i*8 +: 8] = 8'(i + 1);
      vec[2].map   = 32'hFFFFFFFF;
      vec[2].packd = vec[2].data;
      vec[3] = '{data: {8'hAB, 248'h0}, map: 32'h80000000, packd: 256'hAB};
      vec[4] = '{data: 256'h11, map: 32'h00000001, packd: 256'h11};
      vec[5] = '{data: {8'h44, 216'h0, 8'h33, 16'h0, 8'h22}, map: 32'h80000009, packd: 256'h443322};
      vec[6] = '{data: (256'h80 << 128) | (256'h01 << 64), map: 32'h00010100, packd: 256'h8001};
      vec[7] = '{data: 256'hFFFFFFFF << 32, map: 32'h000000F0, packd: 256'hFFFFFFFF};

      rst             = 1'b1;
      bus.start_i     = 1'b0;
      bus.chunk_num_i = '0;
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // two-chunk load, one table vector per beat, back to back
      start_load(2);
      for (int k = 0; k < 8; k++) begin
         bus.in_valid_i = 1'b1;
         bus.in_data_i  = vec[k].data;
         @(posedge clk);
         #1;
         check($sformatf("v%0d wr_valid", k), 256'(bus.wr_valid_o), 256'(1));
         check($sformatf("v%0d map", k),      256'(bus.wr_sparsemap_o), 256'(vec[k].map));
         check($sformatf("v%0d data", k),     bus.wr_nonzero_data_o, vec[k].packd);
         check($sformatf("v%0d dat_cnt", k),  256'(bus.wr_dat_count_o), 256'(k % 4));
         check($sformatf("v%0d chk_cnt", k),  256'(bus.wr_chunk_count_o), 256'(k / 4));
         check($sformatf("v%0d done", k),     256'(bus.done_o), 256'(k == 7));
         @(negedge clk);
      end
      check("after-last in_ready", 256'(bus.in_ready_o), 256'(0));
      check("after-last busy",     256'(bus.busy_o), 256'(1));
      bus.in_valid_i = 1'b0;
      @(posedge clk);
      #1;
      check("idle wr_valid",  256'(bus.wr_valid_o), 256'(0));
      check("idle done",      256'(bus.done_o), 256'(0));
      check("idle busy",      256'(bus.busy_o), 256'(0));
      check("idle map hold",  256'(bus.wr_sparsemap_o), 256'(vec[7].map));
      check("idle chk hold",  256'(bus.wr_chunk_count_o), 256'(1));

      // zero-chunk start must be ignored
      start_load(0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("zero-start busy",  256'(bus.busy_o), 256'(0));
         check("zero-start done",  256'(bus.done_o), 256'(0));
         check("zero-start ready", 256'(bus.in_ready_o), 256'(0));
      end

      // full SRAM load with gaps and a stray start mid-load
      start_load(16);
      n = 0;
      for (int cyc = 0; cyc < 2000 && n < 64; cyc++) begin
         logic v;
         v = (cyc % 5 == 2) ? 1'b0 : 1'($urandom_range(0, 1));
         bus.in_valid_i  = v;
         bus.in_data_i   = vec[cyc % 8].data;
         bus.start_i     = (cyc == 10);
         bus.chunk_num_i = (cyc == 10) ? chunk_num_t'(1) : chunk_num_t'(16);
         @(posedge clk);
         #1;
         check("gap wr_valid", 256'(bus.wr_valid_o), 256'(v));
         if (v) begin
            check("gap dat_cnt", 256'(bus.wr_dat_count_o), 256'(n % 4));
            check("gap chk_cnt", 256'(bus.wr_chunk_count_o), 256'(n / 4));
            check("gap map",     256'(bus.wr_sparsemap_o), 256'(vec[cyc % 8].map));
            check("gap done",    256'(bus.done_o), 256'(n == 63));
            n++;
         end else begin
            check("gap idle done", 256'(bus.done_o), 256'(0));
         end
         @(negedge clk);
         bus.start_i = 1'b0;
      end
      check("gap writes", 256'(n), 256'(64));
      check("gap final chunk", 256'(bus.wr_chunk_count_o), 256'(15));
      bus.in_valid_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("post-load wr_valid", 256'(bus.wr_valid_o), 256'(0));
         @(negedge clk);
      end
      check("post-load busy", 256'(bus.busy_o), 256'(0));
      bus.in_valid_i = 1'b0;

      // reset held two cycles in the middle of a load
      start_load(3);
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = vec[0].data;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("mid-load reset");
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("post-reset wr_valid", 256'(bus.wr_valid_o), 256'(0));
         check("post-reset in_ready", 256'(bus.in_ready_o), 256'(0));
         @(negedge clk);
      end
      bus.in_valid_i = 1'b0;

`ifdef NZ_STATS_EN
      begin
         beat_t nzb [4];
         nzb[0] = 256'h010203;
         nzb[1] = '0;
         nzb[2] = vec[2].data;
         nzb[3] = 256'h5;
         start_load(1);
         for (int k = 0; k < 4; k++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = nzb[k];
            @(posedge clk);
            #1;
            check($sformatf("nz%0d valid", k), 256'(bus.nz_count_valid_o), 256'(k == 3));
            if (k == 3) check("nz count", 256'(bus.nz_count_o), 256'(36));
            @(negedge clk);
         end
         bus.in_valid_i = 1'b0;
         @(posedge clk);
         #1;
         check("nz valid drop", 256'(bus.nz_count_valid_o), 256'(0));
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
